// File: rtl/cache_dm_param_pkg.sv
// cache_dm_param_pkg: rw/state encodings and request/address field-slice macros
`timescale 1ns/1ps
`ifndef CACHE_DM_PARAM_PKG_SV
`define CACHE_DM_PARAM_PKG_SV
`define REQ_RW(r) r[DATA_WIDTH+ADDR_WIDTH]
`define REQ_DATA(r) r[ADDR_WIDTH+:DATA_WIDTH]
`define REQ_ADDR(r) r[ADDR_WIDTH-1:0]
`define ADDR_TAG(a) a[ADDR_WIDTH-1-:TAG_BITS]
`define ADDR_INDEX(a) a[OFFSET_BITS+:INDEX_BITS]
`define ADDR_OFFSET(a) a[OFFSET_BITS-1:0]
package cache_dm_param_pkg;
  localparam logic READ = 1'b0;
  localparam logic WRITE = 1'b1;
  typedef enum logic [1:0] {IDLE, COMPARE_TAG, MEM_REQ, WAIT_ON_MEMORY} state_t;
endpackage
`endif

// File: rtl/cache_dm_tag_array.sv
// cache_dm_tag_array: valid/tag/line storage with read, update and invalidate ports;
// an invalidate matching the stored or the incoming fill tag overrides a same-cycle update.
`timescale 1ns/1ps
module cache_dm_tag_array #(
  parameter int INDEX_BITS = 7,
  parameter int TAG_BITS = 8,
  parameter int DATA_WIDTH = 8,
  parameter int WORDS_PER_BLOCK = 2,
  localparam int OFFSET_BITS = $clog2(WORDS_PER_BLOCK),
  localparam int LINE_W = DATA_WIDTH * WORDS_PER_BLOCK
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [INDEX_BITS-1:0]  rd_index,
  output logic                   rd_valid,
  output logic [TAG_BITS-1:0]    rd_tag,
  output logic [LINE_W-1:0]      rd_line,
  input  logic [INDEX_BITS-1:0]  upd_index,
  input  logic [TAG_BITS-1:0]    upd_tag,
  input  logic                   fill_en,
  input  logic [LINE_W-1:0]      fill_line,
  input  logic                   word_en,
  input  logic [OFFSET_BITS-1:0] word_offset,
  input  logic [DATA_WIDTH-1:0]  word_data,
  input  logic                   inv_en,
  input  logic [INDEX_BITS-1:0]  inv_index,
  input  logic [TAG_BITS-1:0]    inv_tag
);
  localparam int LINES = 2 ** INDEX_BITS;
  logic [LINES-1:0] valid;
  logic [TAG_BITS-1:0] tags [LINES];
  logic [LINE_W-1:0] lines [LINES];
  logic inv_hit;
  assign rd_valid = valid[rd_index];
  assign rd_tag = tags[rd_index];
  assign rd_line = lines[rd_index];
  assign inv_hit = inv_en && ((valid[inv_index] && tags[inv_index] == inv_tag) ||
                              (fill_en && upd_index == inv_index && upd_tag == inv_tag));
  always_ff @(posedge clock or negedge reset)
    if (!reset) valid <= '0;
    else begin
      if (fill_en) valid[upd_index] <= 1'b1;
      if (inv_hit) valid[inv_index] <= 1'b0;
    end
  always_ff @(posedge clock) begin
    if (fill_en) begin
      tags[upd_index] <= upd_tag;
      lines[upd_index] <= fill_line;
    end
    if (word_en) lines[upd_index][word_offset*DATA_WIDTH+:DATA_WIDTH] <= word_data;
  end
endmodule

// File: rtl/cache_dm_param.sv
// cache_dm_param: direct-mapped write-through no-write-allocate cache with handshaked ports.
// Define CACHE_STATS_EN to add saturating read hit_count/miss_count outputs.
`timescale 1ns/1ps
module cache_dm_param
  import cache_dm_param_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int WORDS_PER_BLOCK = 2,
  parameter int INDEX_BITS = 7,
  localparam int OFFSET_BITS = $clog2(WORDS_PER_BLOCK),
  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS,
  localparam int REQ_W = 1 + DATA_WIDTH + ADDR_WIDTH,
  localparam int LINE_W = DATA_WIDTH * WORDS_PER_BLOCK
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REQ_W-1:0]      cpu_request,
  input  logic                  cpu_request_ready,
  output logic                  cpu_request_accept,
  input  logic [ADDR_WIDTH-1:0] invalidate_address,
  input  logic                  invalidate_valid,
  output logic [REQ_W-1:0]      memory_request,
  output logic                  memory_request_ready,
  input  logic                  memory_request_accept,
  input  logic [LINE_W-1:0]     memory_response,
  input  logic                  memory_response_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count
`endif
);
  state_t state, next;
  logic [REQ_W-1:0] req;
  logic [ADDR_WIDTH-1:0] addr;
  logic [TAG_BITS-1:0] tag, rd_tag;
  logic [INDEX_BITS-1:0] index;
  logic [OFFSET_BITS-1:0] offset;
  logic [LINE_W-1:0] rd_line;
  logic is_write, rd_valid, hit, read_hit, fill_en, word_en;
  assign addr = `REQ_ADDR(req);
  assign tag = `ADDR_TAG(addr);
  assign index = `ADDR_INDEX(addr);
  assign offset = `ADDR_OFFSET(addr);
  assign is_write = `REQ_RW(req) == WRITE;
  assign hit = rd_valid && rd_tag == tag;
  assign read_hit = hit && !is_write;
  assign cpu_request_accept = reset && state == IDLE;
  assign fill_en = state == WAIT_ON_MEMORY && memory_response_ready && !is_write;
  assign word_en = state == COMPARE_TAG && is_write && hit;
  cache_dm_tag_array #(
    .INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS),
    .DATA_WIDTH(DATA_WIDTH), .WORDS_PER_BLOCK(WORDS_PER_BLOCK)
  ) u_array (
    .clock(clock), .reset(reset),
    .rd_index(index), .rd_valid(rd_valid), .rd_tag(rd_tag), .rd_line(rd_line),
    .upd_index(index), .upd_tag(tag),
    .fill_en(fill_en), .fill_line(memory_response),
    .word_en(word_en), .word_offset(offset), .word_data(`REQ_DATA(req)),
    .inv_en(invalidate_valid), .inv_index(`ADDR_INDEX(invalidate_address)),
    .inv_tag(`ADDR_TAG(invalidate_address))
  );
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= next;
  always_comb
    next = state == IDLE ? (cpu_request_ready ? COMPARE_TAG : IDLE)
      : state == COMPARE_TAG ? (read_hit ? IDLE : MEM_REQ)
      : state == MEM_REQ ? (memory_request_accept ? WAIT_ON_MEMORY : MEM_REQ)
      : (memory_response_ready ? IDLE : WAIT_ON_MEMORY);
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      req <= '0;
      memory_request <= '0;
      memory_request_ready <= 1'b0;
      data_out <= '0;
      data_out_ready <= 1'b0;
    end else begin
      data_out_ready <= 1'b0;
      if (cpu_request_accept && cpu_request_ready) req <= cpu_request;
      if (state == COMPARE_TAG && read_hit) begin
        data_out <= rd_line[offset*DATA_WIDTH+:DATA_WIDTH];
        data_out_ready <= 1'b1;
      end
      if (state == COMPARE_TAG && !read_hit) begin
        memory_request <= is_write ? req : {READ, {DATA_WIDTH{1'b0}}, addr};
        memory_request_ready <= 1'b1;
      end
      if (state == MEM_REQ && memory_request_accept) memory_request_ready <= 1'b0;
      if (state == WAIT_ON_MEMORY && memory_response_ready) begin
        data_out_ready <= 1'b1;
        if (!is_write) data_out <= memory_response[offset*DATA_WIDTH+:DATA_WIDTH];
      end
    end
`ifdef CACHE_STATS_EN
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      hit_count <= '0;
      miss_count <= '0;
    end else if (state == COMPARE_TAG && !is_write) begin
      if (hit) hit_count <= hit_count + 16'(hit_count != 16'hFFFF);
      else miss_count <= miss_count + 16'(miss_count != 16'hFFFF);
    end
`endif
endmodule

// File: tb/tb_cache_dm_param.sv
// tb_cache_dm_param: directed plan plus random traffic against a block-residency/memory model.
`timescale 1ns/1ps
module tb_cache_dm_param;
  logic clock = 0, reset = 0;
  logic [24:0] cpu_request = '0, memory_request;
  logic cpu_request_ready = 0, cpu_request_accept;
  logic [15:0] invalidate_address = '0, memory_response = '0;
  logic invalidate_valid = 0, memory_request_ready, memory_request_accept = 0, memory_response_ready = 0;
  logic [7:0] data_out;
  logic data_out_ready;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif
  cache_dm_param dut (
    .clock(clock), .reset(reset),
    .cpu_request(cpu_request), .cpu_request_ready(cpu_request_ready), .cpu_request_accept(cpu_request_accept),
    .invalidate_address(invalidate_address), .invalidate_valid(invalidate_valid),
    .memory_request(memory_request), .memory_request_ready(memory_request_ready),
    .memory_request_accept(memory_request_accept),
    .memory_response(memory_response), .memory_response_ready(memory_response_ready),
    .data_out(data_out), .data_out_ready(data_out_ready)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );
  always #5 clock = ~clock;
  int n_checks = 0, n_fail = 0;
  logic [7:0] mem [logic [15:0]];
  int resident [128];
  logic [7:0] last_dout = '0;
  int hits_m = 0, misses_m = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : 8'(a * 7 + (a >> 8) + 3);
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 128; i++) resident[i] = -1;
    last_dout = '0;
    hits_m = 0;
    misses_m = 0;
  endtask
  task automatic model_inv(input logic [15:0] a);
    if (resident[(int'(a) / 2) % 128] == int'(a) / 2) resident[(int'(a) / 2) % 128] = -1;
  endtask
  task automatic inv(input logic [15:0] a);
    invalidate_address = a;
    invalidate_valid = 1;
    @(posedge clock); #1 invalidate_valid = 0;
    model_inv(a);
  endtask
  task automatic xact(input bit w, input logic [7:0] d, input logic [15:0] a, input bit inv_resp,
                      input int hold, input int lat);
    int blk, set;
    bit hit;
    logic [24:0] exp_req;
    blk = int'(a) / 2;
    set = blk % 128;
    hit = resident[set] == blk;
    exp_req = w ? {1'b1, d, a} : {1'b0, 8'h00, a};
    chk("accept_idle", cpu_request_accept, 1);
    cpu_request = {w, d, a};
    cpu_request_ready = 1;
    @(posedge clock); #1 cpu_request_ready = 0;
    cpu_request = 25'($urandom);
    chk("no_pulse_compare", data_out_ready, 0);
    @(posedge clock); #1;
    if (!w) begin
      if (hit) hits_m++;
      else misses_m++;
    end
    if (!w && hit) begin
      last_dout = mem_rd(a);
      chk("hit_pulse", data_out_ready, 1);
      chk("hit_data", data_out, last_dout);
      chk("hit_no_mem", memory_request_ready, 0);
    end else begin
      chk("mem_req_ready", memory_request_ready, 1);
      chk("mem_req", memory_request, exp_req);
      chk("miss_no_pulse", data_out_ready, 0);
      repeat (hold) begin
        @(posedge clock); #1;
        chk("req_held", memory_request_ready, 1);
        chk("req_stable", memory_request, exp_req);
      end
      memory_request_accept = 1;
      @(posedge clock); #1 memory_request_accept = 0;
      chk("req_dropped", memory_request_ready, 0);
      repeat (lat) begin
        @(posedge clock); #1 chk("wait_no_pulse", data_out_ready, 0);
      end
      if (w) mem[a] = d;
      memory_response = w ? 16'($urandom) : {mem_rd({a[15:1], 1'b1}), mem_rd({a[15:1], 1'b0})};
      memory_response_ready = 1;
      if (inv_resp) begin
        invalidate_address = a;
        invalidate_valid = 1;
      end
      @(posedge clock); #1 memory_response_ready = 0;
      invalidate_valid = 0;
      memory_response = 16'($urandom);
      if (!w) begin
        last_dout = mem_rd(a);
        resident[set] = inv_resp ? -1 : blk;
      end else if (inv_resp) model_inv(a);
      chk("done_pulse", data_out_ready, 1);
      chk("done_data", data_out, last_dout);
    end
    @(posedge clock); #1 chk("pulse_one_cycle", data_out_ready, 0);
  endtask
  logic [7:0] tg [4] = '{8'h12, 8'h34, 8'h99, 8'hA0};
  logic [6:0] ix [4] = '{7'h1A, 7'h00, 7'h7F, 7'h05};
  initial begin
    model_reset();
    mem[16'h1234] = 8'hEF;
    mem[16'h1235] = 8'hBE;
    #1;
    chk("rst_accept", cpu_request_accept, 0);
    chk("rst_mreq", memory_request, 0);
    chk("rst_mready", memory_request_ready, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_dready", data_out_ready, 0);
    #11 reset = 1;
    @(posedge clock); #1;
    xact(0, 0, 16'h1234, 0, 0, 0);
    xact(0, 0, 16'h1235, 0, 0, 0);
    xact(1, 8'h55, 16'h1235, 0, 1, 1);
    xact(0, 0, 16'h1235, 0, 0, 0);
    xact(0, 0, 16'h1234, 0, 0, 0);
`ifdef CACHE_STATS_EN
    chk("hit_count", hit_count, 3);
    chk("miss_count", miss_count, 1);
`endif
    xact(1, 8'h11, 16'h4400, 0, 0, 0);
    xact(0, 0, 16'h4400, 0, 0, 2);
    inv(16'h9934);
    xact(0, 0, 16'h1234, 0, 0, 0);
    inv(16'h1234);
    xact(0, 0, 16'h1234, 0, 0, 0);
    inv(16'h1234);
    xact(0, 0, 16'h1234, 1, 0, 1);
    xact(0, 0, 16'h1234, 0, 0, 0);
    xact(0, 0, 16'h2468, 0, 5, 0);
    cpu_request = {1'b0, 8'h00, 16'h0800};
    cpu_request_ready = 1;
    @(posedge clock); #1 cpu_request_ready = 0;
    @(posedge clock); #1 chk("r5_mreq_ready", memory_request_ready, 1);
    memory_request_accept = 1;
    @(posedge clock); #2 memory_request_accept = 0;
    reset = 0;
    #1;
    chk("mid_rst_accept", cpu_request_accept, 0);
    chk("mid_rst_mreq", memory_request, 0);
    chk("mid_rst_mready", memory_request_ready, 0);
    chk("mid_rst_dout", data_out, 0);
    chk("mid_rst_dready", data_out_ready, 0);
    model_reset();
    #3 reset = 1;
    @(posedge clock); #1;
    xact(0, 0, 16'h1234, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      logic [15:0] a;
      int op;
      a = {tg[$urandom_range(0, 3)], ix[$urandom_range(0, 3)], 1'($urandom)};
      op = $urandom_range(0, 8);
      if (op <= 4) xact(0, 0, a, $urandom_range(0, 7) == 0, $urandom_range(0, 3), $urandom_range(0, 3));
      else if (op <= 6) xact(1, 8'($urandom), a, $urandom_range(0, 7) == 0, $urandom_range(0, 3), $urandom_range(0, 3));
      else if (op == 7) inv(a);
      else begin
        memory_response = 16'($urandom);
        memory_response_ready = 1;
        @(posedge clock); #1 memory_response_ready = 0;
        chk("stray_resp_ignored", data_out_ready, 0);
      end
    end
`ifdef CACHE_STATS_EN
    chk("hit_count_final", hit_count, hits_m);
    chk("miss_count_final", miss_count, misses_m);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
